gsm_rx_parser: RTL

- UART receiver plus AT-response line parser on the GSM module's TX pin; sits directly downstream of the AT-command transmitter.
- Deserialises 8N1 bytes and assembles CR-terminated lines.
- Classifies each line as OK / ERROR / RING / NO CARRIER and pulses one flag per recognised line.
- The command sequencer uses these flags to advance or abort instead of relying on blind fixed delays.

---
 rtl/gsm_rx_parser_pkg.sv | 61 ++++++
 rtl/gsm_rx_parser_if.sv | 32 +++
 rtl/gsm_rx_parser_uart_rx.sv | 104 ++++++++++
 rtl/gsm_rx_parser.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gsm_rx_parser_pkg.sv
// ============================================================================
// Module : gsm_pkg
// Brief  : Shared constants, keyword table and enums for the GSM RX parser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gsm_pkg;

    localparam int CLK_DIV_DEFAULT = 2500;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Keywords are right-justified string literals; KW_MAX bounds the longest one.
    localparam int unsigned KW_MAX = 10;
    localparam logic [8*KW_MAX-1:0] KW_OK        = "OK";
    localparam logic [8*KW_MAX-1:0] KW_ERROR     = "ERROR";
    localparam logic [8*KW_MAX-1:0] KW_RING      = "RING";
    localparam logic [8*KW_MAX-1:0] KW_NOCARRIER = "NO CARRIER";
    localparam int unsigned KW_OK_LEN        = 2;
    localparam int unsigned KW_ERROR_LEN     = 5;
    localparam int unsigned KW_RING_LEN      = 4;
    localparam int unsigned KW_NOCARRIER_LEN = 10;

    typedef enum logic [2:0] {
        RESP_NONE,
        RESP_OK,
        RESP_ERROR,
        RESP_RING,
        RESP_NOCARRIER,
        RESP_TIMEOUT
    } resp_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // win[0] is the first character of the line.
    function automatic logic kw_match(
        input logic [KW_MAX-1:0][7:0] win,
        input int unsigned            len,
        input logic [8*KW_MAX-1:0]    kw,
        input int unsigned            kw_len
    );
        logic hit;
        hit = (len == kw_len);
        for (int unsigned i = 0; i < KW_MAX; i++) begin
            if ((i < kw_len) && (win[i] != kw[8*(kw_len-1-i) +: 8])) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gsm_rx_parser_if.sv
// ============================================================================
// Module : gsm_rx_if
// Brief  : Byte/response bundle between the RX parser and the command sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface gsm_rx_if;
    logic       cmd_sent;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       resp_ok;
    logic       resp_error;
    logic       resp_ring;
    logic       resp_nocarrier;
    logic       resp_timeout;

    modport master (
        input  cmd_sent,
        output rx_data, rx_valid, frame_err,
        output resp_ok, resp_error, resp_ring, resp_nocarrier, resp_timeout
    );

    modport slave (
        output cmd_sent,
        input  rx_data, rx_valid, frame_err,
        input  resp_ok, resp_error, resp_ring, resp_nocarrier, resp_timeout
    );
endinterface

`default_nettype wire

// File: rtl/gsm_rx_parser_uart_rx.sv
// ============================================================================
// Module : gsm_uart_rx
// Brief  : 8N1 UART receiver with two-flop synchroniser and mid-bit sampling.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gsm_uart_rx
    import gsm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_line_rx,
    output logic [7:0]      o_rx_data,
    output logic            o_rx_valid,
    output logic            o_frame_err
);

    localparam int                 c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLK_DIV / 2 - 1);

    logic [1:0]         r_sync;
    logic               r_rx_d;
    rx_state_e          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               w_fall;
    logic               w_rx_s;

    assign w_rx_s = r_sync[1];
    assign w_fall = r_rx_d & ~w_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= 2'b11;
            r_rx_d      <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_line_rx};
            r_rx_d      <= w_rx_s;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_rx_s) begin
                            o_rx_data  <= r_shift;
                            o_rx_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gsm_rx_parser.sv
// ============================================================================
// Module : gsm_rx_parser
// Brief  : UART RX + AT-response line classifier (OK/ERROR/RING/NO CARRIER).
//          Optional response watchdog enabled by macro GSM_RX_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gsm_rx_parser
    import gsm_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int LINE_MAX    = 12,
    parameter int TIMEOUT_CYC = 24000000
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  line_rx,
    gsm_rx_if.master   bus
);

    localparam int                 c_LEN_W    = $clog2(LINE_MAX + 1);
    localparam logic [c_LEN_W-1:0] c_LINE_MAX = c_LEN_W'(LINE_MAX);

    logic [7:0]                  w_rx_data;
    logic                        w_rx_valid;
    logic                        w_frame_err;
    logic [LINE_MAX-1:0][7:0]    r_buf;
    logic [c_LEN_W-1:0]          r_len;
    logic                        r_ovf;
    resp_e                       r_code;
    resp_e                       w_match;
    logic [KW_MAX-1:0][7:0]      w_win;
    logic                        r_resp_ok;
    logic                        r_resp_error;
    logic                        r_resp_ring;
    logic                        r_resp_nocarrier;
    logic                        r_resp_timeout;

    gsm_uart_rx #(
        .CLK_DIV     (CLK_DIV)
    ) u_uart_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_line_rx   (line_rx),
        .o_rx_data   (w_rx_data),
        .o_rx_valid  (w_rx_valid),
        .o_frame_err (w_frame_err)
    );

    genvar gi;
    generate
        for (gi = 0; gi < KW_MAX; gi++) begin : g_win
            if (gi < LINE_MAX) begin : g_used
                assign w_win[gi] = r_buf[gi];
            end else begin : g_pad
                assign w_win[gi] = 8'h00;
            end
        end
        // Characters past the longest keyword only matter through r_len.
        if (LINE_MAX > KW_MAX) begin : g_tail
            logic w_unused_tail;
            assign w_unused_tail = ^r_buf[LINE_MAX-1:KW_MAX];
        end
    endgenerate

    always_comb begin
        w_match = RESP_NONE;
        if (kw_match(w_win, 32'(r_len), KW_OK, KW_OK_LEN)) begin
            w_match = RESP_OK;
        end else if (kw_match(w_win, 32'(r_len), KW_ERROR, KW_ERROR_LEN)) begin
            w_match = RESP_ERROR;
        end else if (kw_match(w_win, 32'(r_len), KW_RING, KW_RING_LEN)) begin
            w_match = RESP_RING;
        end else if (kw_match(w_win, 32'(r_len), KW_NOCARRIER, KW_NOCARRIER_LEN)) begin
            w_match = RESP_NOCARRIER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
            r_code <= RESP_NONE;
        end else begin
            r_code <= RESP_NONE;
            if (w_frame_err) begin
                r_len <= '0;
                r_ovf <= 1'b0;
            end else if (w_rx_valid) begin
                if (w_rx_data == CHAR_CR) begin
                    if ((r_len != '0) && !r_ovf) begin
                        r_code <= w_match;
                    end
                    r_len <= '0;
                    r_ovf <= 1'b0;
                end else if (w_rx_data != CHAR_LF) begin
                    if (r_len < c_LINE_MAX) begin
                        r_buf[r_len] <= w_rx_data;
                        r_len        <= r_len + 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_ok        <= 1'b0;
            r_resp_error     <= 1'b0;
            r_resp_ring      <= 1'b0;
            r_resp_nocarrier <= 1'b0;
        end else begin
            r_resp_ok        <= (r_code == RESP_OK);
            r_resp_error     <= (r_code == RESP_ERROR);
            r_resp_ring      <= (r_code == RESP_RING);
            r_resp_nocarrier <= (r_code == RESP_NOCARRIER);
        end
    end

`ifdef GSM_RX_TIMEOUT_EN
    localparam int                 c_WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_WD_W-1:0]             r_wd_cnt;
    logic                          r_wd_run;
    logic                          w_term;

    assign w_term = r_resp_ok | r_resp_error | r_resp_nocarrier;

    // Expiry is flagged one count early so the pulse lands on the zero cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt       <= '0;
            r_wd_run       <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else begin
            r_resp_timeout <= 1'b0;
            if (bus.cmd_sent) begin
                r_wd_cnt       <= c_WD_W'(TIMEOUT_CYC - 1);
                r_wd_run       <= (TIMEOUT_CYC > 1);
                r_resp_timeout <= (TIMEOUT_CYC == 1);
            end else if (r_wd_run) begin
                if (w_term) begin
                    r_wd_run <= 1'b0;
                end else if (r_wd_cnt == c_WD_W'(1)) begin
                    // Hold off one cycle while a line response is in flight.
                    if (r_code == RESP_NONE) begin
                        r_resp_timeout <= 1'b1;
                        r_wd_run       <= 1'b0;
                        r_wd_cnt       <= '0;
                    end
                end else begin
                    r_wd_cnt <= r_wd_cnt - 1'b1;
                end
            end
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYC;
    logic          w_unused_cmd;
    assign w_unused_cmd   = bus.cmd_sent;
    assign r_resp_timeout = 1'b0;
`endif

    assign bus.rx_data        = w_rx_data;
    assign bus.rx_valid       = w_rx_valid;
    assign bus.frame_err      = w_frame_err;
    assign bus.resp_ok        = r_resp_ok;
    assign bus.resp_error     = r_resp_error;
    assign bus.resp_ring      = r_resp_ring;
    assign bus.resp_nocarrier = r_resp_nocarrier;
    assign bus.resp_timeout   = r_resp_timeout;

endmodule

`default_nettype wire
